// File: rtl/ahb_slave_mem_ws_pkg.sv
// Shared definitions for the AHB memory slave with wait states:
// HTRANS/HRESP encodings, the data-phase FSM state enum and the
// byte-lane mask helper.
package ahb_slave_mem_ws_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Byte lanes touched by a transfer of 2**hsize bytes starting at the
    // byte offset addr_lo inside the data word. Callers only pass aligned
    // combinations; bit 0 is the least significant byte lane.
    function automatic logic [7:0] lane_mask(input logic [2:0] hsize,
                                             input logic [2:0] addr_lo);
        logic [7:0] base;
        case (hsize)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << addr_lo;
    endfunction

endpackage

// File: rtl/ahb_slave_mem_ws_ram.sv
// DEPTH x DWIDTH storage with per-byte write enables and a registered
// read port. The read register holds its value while re is low.
// Ports: clk, we/be/waddr/wdata (write), re/raddr (read), rdata.
module ahb_slave_mem_ws_ram #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DWIDTH/8-1:0]      be,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DWIDTH-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DWIDTH-1:0]        rdata
);
    localparam int BYTES = DWIDTH / 8;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    // Storage is deliberately not reset so contents survive HRESET.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ahb_slave_mem_ws.sv
// AHB-Lite memory slave with a fixed number of wait states per OKAY
// transfer and a two-cycle ERROR response for bad size, misalignment or
// a configurable address region.
// Ports: HCLK/HRESET (async, active high), AHB address/control inputs,
// HWDATA, HREADYIN; outputs HREADYOUT, HRDATA, HRESP.
module ahb_slave_mem_ws
    import ahb_slave_mem_ws_pkg::*;
#(
    parameter int                AWIDTH      = 16,
    parameter int                DWIDTH      = 32,
    parameter int                DEPTH       = 256,
    parameter int                WAIT_STATES = 0,
    parameter int                ERR_EN      = 0,
    parameter logic [AWIDTH-1:0] ERR_BASE    = '0,
    parameter logic [AWIDTH-1:0] ERR_MASK    = '0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [AWIDTH-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DWIDTH-1:0] HWDATA,
    input  logic              HREADYIN,
    output logic              HREADYOUT,
    output logic [DWIDTH-1:0] HRDATA,
    output logic              HRESP
);
    localparam int         BYTES = DWIDTH / 8;
    localparam int         BL    = $clog2(BYTES);
    localparam int         IW    = $clog2(DEPTH);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    state_e             state_q, state_d;
    logic [3:0]         wcnt_q, wcnt_d;
    logic               pend_q, pend_d;      // OKAY data phase outstanding
    logic               write_q, write_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [BYTES-1:0]   lanes_q, lanes_d;
    logic [DWIDTH-1:0]  byp_mask_q, byp_mask_d;
    logic [DWIDTH-1:0]  byp_data_q, byp_data_d;

    logic               ready, accept, addr_err, final_dp, wr_fire;
    logic [IW-1:0]      haddr_idx;
    logic [7:0]         lane_full, align_m;
    logic [BYTES-1:0]   lane_sel;
    logic [DWIDTH-1:0]  wr_bitmask, ram_rdata;
    logic               unused_ok;

    assign unused_ok = ^{HBURST, lane_full, HTRANS_IDLE, HTRANS_BUSY};

    assign haddr_idx = HADDR[IW+BL-1:BL];
    assign lane_full = lane_mask(HSIZE, 3'(HADDR[BL-1:0]));
    assign lane_sel  = lane_full[BYTES-1:0];
    assign accept    = HSEL & HREADYIN & ready &
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign final_dp  = pend_q & ready;
    assign wr_fire   = final_dp & write_q;

    always_comb begin
        align_m  = (8'd1 << HSIZE) - 8'd1;
        addr_err = (HSIZE > 3'(BL)) ||
                   ((8'(HADDR[2:0]) & align_m) != 8'd0) ||
                   ((ERR_EN != 0) && ((HADDR & ERR_MASK) == ERR_BASE));
    end

    always_comb begin
        wr_bitmask = '0;
        for (int b = 0; b < BYTES; b++) wr_bitmask[8*b +: 8] = {8{lanes_q[b]}};
    end

    // State register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= '0;
            pend_q     <= 1'b0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            lanes_q    <= '0;
            byp_mask_q <= '0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            pend_q     <= pend_d;
            write_q    <= write_d;
            idx_q      <= idx_d;
            lanes_q    <= lanes_d;
            byp_mask_q <= byp_mask_d;
            byp_data_q <= byp_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        pend_d     = pend_q;
        write_d    = write_q;
        idx_d      = idx_q;
        lanes_d    = lanes_q;
        byp_mask_d = byp_mask_q;
        byp_data_d = byp_data_q;
        case (state_q)
            ST_WAIT: if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
            ST_ERR1: state_d = ST_ERR2;
            default: ;
        endcase
        // Any cycle with HREADYOUT high ends the current data phase and may
        // start the next one (pipelined back-to-back transfers).
        if (ready) begin
            state_d    = ST_IDLE;
            pend_d     = 1'b0;
            byp_mask_d = '0;
            if (accept) begin
                if (addr_err) begin
                    state_d = ST_ERR1;
                end else begin
                    pend_d  = 1'b1;
                    write_d = HWRITE;
                    idx_d   = haddr_idx;
                    lanes_d = lane_sel;
                    wcnt_d  = WS;
                    state_d = (WS != 4'd0) ? ST_WAIT : ST_IDLE;
                    // The RAM read at this edge sees the pre-write word, so
                    // keep the lanes being written now to merge them later.
                    if (wr_fire && !HWRITE && (idx_q == haddr_idx))
                        byp_mask_d = wr_bitmask;
                    byp_data_d = HWDATA;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        case (state_q)
            ST_WAIT: ready = (wcnt_q == 4'd0);
            ST_ERR1: ready = 1'b0;
            default: ready = 1'b1;
        endcase
        HREADYOUT = ready;
        HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        HRDATA    = '0;
        if (final_dp && !write_q)
            HRDATA = (ram_rdata & ~byp_mask_q) | (byp_data_q & byp_mask_q);
    end

    ahb_slave_mem_ws_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (HCLK),
        .we    (wr_fire),
        .be    (lanes_q),
        .waddr (idx_q),
        .wdata (HWDATA),
        .re    (accept & ~HWRITE),
        .raddr (haddr_idx),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_ahb_slave_mem_ws.sv
module tb_ahb_slave_mem_ws;
    import ahb_slave_mem_ws_pkg::*;

    logic        clk = 1'b0;
    logic        hrst = 1'b1;
    logic        hsel0 = 1'b0, hsel3 = 1'b0, rin = 1'b1;
    logic [15:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic [2:0]  hsize = 3'd2;
    logic [2:0]  hburst = 3'd0;
    logic [31:0] hwdata = '0;
    logic        hreadyout0, hreadyout3, hresp0, hresp3;
    logic        hreadyin0, hreadyin3;
    logic [31:0] hrdata0, hrdata3;

    assign hreadyin0 = rin & hreadyout0;
    assign hreadyin3 = hreadyout3;

    always #5 clk = ~clk;

    ahb_slave_mem_ws #(
        .WAIT_STATES(0), .ERR_EN(1), .ERR_BASE(16'h8000), .ERR_MASK(16'h8000)
    ) dut0 (
        .HCLK(clk), .HRESET(hrst), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADYIN(hreadyin0), .HREADYOUT(hreadyout0), .HRDATA(hrdata0), .HRESP(hresp0)
    );

    ahb_slave_mem_ws #(
        .WAIT_STATES(3)
    ) dut3 (
        .HCLK(clk), .HRESET(hrst), .HSEL(hsel3), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADYIN(hreadyin3), .HREADYOUT(hreadyout3), .HRDATA(hrdata3), .HRESP(hresp3)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [15:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        rin;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NV = 24;
    vec_t tv [NV];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(logic sel, logic [1:0] tr, logic wr, logic [15:0] a,
                                logic [2:0] sz, logic [31:0] wd, logic ri,
                                logic er, logic ep, logic [31:0] ed);
        vec_t v;
        v.sel = sel; v.trans = tr; v.wr = wr; v.addr = a; v.size = sz;
        v.wdata = wd; v.rin = ri; v.e_rdy = er; v.e_resp = ep; v.e_rdata = ed;
        return v;
    endfunction

    // One transfer on the 3-wait-state slave; returns at the negedge inside
    // its final data-phase cycle so the next call can pipeline behind it.
    task automatic xfer3(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                         output int lows, output int rd_nz, output logic [31:0] rd,
                         output logic ok);
        hsel3 = 1'b1; htrans = HTRANS_NONSEQ; hwrite = wr; haddr = addr; hsize = 3'd2;
        @(negedge clk);
        hsel3 = 1'b0; htrans = HTRANS_IDLE; hwdata = wd;
        lows = 0; rd_nz = 0; rd = '0; ok = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (hreadyout3) begin
                ok = 1'b1;
                rd = hrdata3;
                break;
            end
            lows++;
            if (hrdata3 != 32'h0) rd_nz++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lows, rd_nz;
        logic [31:0] rd;
        logic        ok;

        //          sel tr             wr    addr      sz  wdata         rin  rdy resp rdata
        tv[0]  = mk(1, HTRANS_NONSEQ, 1'b1, 16'h0010, 2, 32'h0,        1, 1, 0, 32'h0);
        tv[1]  = mk(1, HTRANS_NONSEQ, 1'b1, 16'h0004, 2, 32'hDEADBEEF, 1, 1, 0, 32'h0);
        tv[2]  = mk(1, HTRANS_NONSEQ, 1'b0, 16'h0010, 2, 32'hCAFEF00D, 1, 1, 0, 32'h0);
        tv[3]  = mk(1, HTRANS_NONSEQ, 1'b1, 16'h0010, 2, 32'h0,        1, 1, 0, 32'hDEADBEEF);
        tv[4]  = mk(1, HTRANS_NONSEQ, 1'b1, 16'h0013, 0, 32'h11223344, 1, 1, 0, 32'h0);
        tv[5]  = mk(1, HTRANS_NONSEQ, 1'b0, 16'h0010, 2, 32'hAA000000, 1, 1, 0, 32'h0);
        tv[6]  = mk(1, HTRANS_NONSEQ, 1'b0, 16'h0004, 2, 32'h0,        1, 1, 0, 32'hAA223344);
        tv[7]  = mk(1, HTRANS_IDLE,   1'b0, 16'h0000, 2, 32'h0,        1, 1, 0, 32'hCAFEF00D);
        tv[8]  = mk(1, HTRANS_NONSEQ, 1'b1, 16'h8004, 2, 32'h0,        1, 1, 0, 32'h0);
        tv[9]  = mk(1, HTRANS_IDLE,   1'b0, 16'h0000, 2, 32'hFFFFFFFF, 1, 0, 1, 32'h0);
        tv[10] = mk(1, HTRANS_IDLE,   1'b0, 16'h0000, 2, 32'h0,        1, 1, 1, 32'h0);
        tv[11] = mk(1, HTRANS_NONSEQ, 1'b0, 16'h0001, 1, 32'h0,        1, 1, 0, 32'h0);
        tv[12] = mk(1, HTRANS_IDLE,   1'b0, 16'h0000, 2, 32'h0,        1, 0, 1, 32'h0);
        tv[13] = mk(1, HTRANS_NONSEQ, 1'b1, 16'h0000, 3, 32'h0,        1, 1, 1, 32'h0);
        tv[14] = mk(1, HTRANS_IDLE,   1'b0, 16'h0000, 2, 32'h55555555, 1, 0, 1, 32'h0);
        tv[15] = mk(1, HTRANS_IDLE,   1'b0, 16'h0000, 2, 32'h0,        1, 1, 1, 32'h0);
        tv[16] = mk(1, HTRANS_NONSEQ, 1'b0, 16'h0004, 2, 32'h0,        1, 1, 0, 32'h0);
        tv[17] = mk(1, HTRANS_NONSEQ, 1'b1, 16'h0020, 2, 32'h0,        1, 1, 0, 32'hCAFEF00D);
        tv[18] = mk(1, HTRANS_NONSEQ, 1'b0, 16'h0420, 2, 32'h12345678, 1, 1, 0, 32'h0);
        tv[19] = mk(0, HTRANS_NONSEQ, 1'b0, 16'h0010, 2, 32'h0,        1, 1, 0, 32'h12345678);
        tv[20] = mk(1, HTRANS_BUSY,   1'b0, 16'h0010, 2, 32'h0,        1, 1, 0, 32'h0);
        tv[21] = mk(1, HTRANS_NONSEQ, 1'b0, 16'h0010, 2, 32'h0,        1, 1, 0, 32'h0);
        tv[22] = mk(1, HTRANS_NONSEQ, 1'b0, 16'h0004, 2, 32'h0,        0, 1, 0, 32'hAA223344);
        tv[23] = mk(1, HTRANS_IDLE,   1'b0, 16'h0000, 2, 32'h0,        1, 1, 0, 32'h0);

        @(negedge clk);
        @(negedge clk);
        chk("reset hreadyout0", 32'(hreadyout0), 32'd1);
        chk("reset hresp0",     32'(hresp0),     32'd0);
        chk("reset hrdata0",    hrdata0,         32'h0);
        chk("reset hreadyout3", 32'(hreadyout3), 32'd1);

        // Release reset and drive the first address phase in the same cycle.
        hrst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("v%0d hreadyout", i), 32'(hreadyout0), 32'(tv[i].e_rdy));
            chk($sformatf("v%0d hresp", i),     32'(hresp0),     32'(tv[i].e_resp));
            chk($sformatf("v%0d hrdata", i),    hrdata0,         tv[i].e_rdata);
            hsel0  = tv[i].sel;
            htrans = tv[i].trans;
            hwrite = tv[i].wr;
            haddr  = tv[i].addr;
            hsize  = tv[i].size;
            hwdata = tv[i].wdata;
            rin    = tv[i].rin;
            @(negedge clk);
        end
        hsel0 = 1'b0; htrans = HTRANS_IDLE; rin = 1'b1;
        @(negedge clk);

        xfer3(1'b1, 16'h0004, 32'h0BADF00D, lows, rd_nz, rd, ok);
        chk("ws write done",  32'(ok),   32'd1);
        chk("ws write lows",  32'(lows), 32'd3);
        chk("ws write hresp", 32'(hresp3), 32'd0);
        xfer3(1'b0, 16'h0004, 32'h0, lows, rd_nz, rd, ok);
        chk("ws read done",   32'(ok),    32'd1);
        chk("ws read lows",   32'(lows),  32'd3);
        chk("ws read rdata",  rd,         32'h0BADF00D);
        chk("ws wait rdata0", 32'(rd_nz), 32'd0);
        chk("ws read hresp",  32'(hresp3), 32'd0);

        // Abort a write during its wait states.
        hsel3 = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 16'h0004; hsize = 3'd2;
        @(negedge clk);
        hsel3 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF;
        chk("abort in wait", 32'(hreadyout3), 32'd0);
        @(negedge clk);
        hrst = 1'b1;
        #1;
        chk("abort hreadyout", 32'(hreadyout3), 32'd1);
        chk("abort hresp",     32'(hresp3),     32'd0);
        chk("abort hrdata",    hrdata3,         32'h0);
        @(negedge clk);
        @(negedge clk);
        hrst = 1'b0;
        xfer3(1'b0, 16'h0004, 32'h0, lows, rd_nz, rd, ok);
        chk("post-reset done",  32'(ok),   32'd1);
        chk("post-reset lows",  32'(lows), 32'd3);
        chk("post-reset rdata", rd,        32'h0BADF00D);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
